// File: rtl/ycbcr_pkg.sv
// Shared types and constants for the RGB->YCbCr frame sequencer.
// Holds the FSM encoding, pipeline latency constants and the output byte packing.
package ycbcr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Source RAM read latency and the converter's stock pipeline depth.
  localparam int RD_LAT           = 1;
  localparam int CONV_LAT_DEFAULT = 3;

  typedef logic [23:0] pixel_t;

  // Bits [15:8] are taken by plain truncation; Cb/Cr wraparound passes through untouched.
  function automatic pixel_t pack_ycc(input logic [15:0] y,
                                      input logic [15:0] cb,
                                      input logic [15:0] cr);
    return {y[15:8], cb[15:8], cr[15:8]};
  endfunction

endpackage

// File: rtl/ycbcr_frame_ctrl_if.sv
// Frame-buffer and converter bus seen by the sequencer.
// The master side is the sequencer; the slave side is the RAMs plus the converter.
interface ycbcr_frame_ctrl_if
  import ycbcr_pkg::*;
#(
  parameter int ADDR_W = 10
);

  logic              src_rd;
  logic [ADDR_W-1:0] src_addr;
  pixel_t            src_rdata;
  pixel_t            conv_data;
  logic [15:0]       conv_y;
  logic [15:0]       conv_cb;
  logic [15:0]       conv_cr;
  logic              dst_wr;
  logic [ADDR_W-1:0] dst_addr;
  pixel_t            dst_wdata;

  modport master (
    output src_rd, src_addr, conv_data, dst_wr, dst_addr, dst_wdata,
    input  src_rdata, conv_y, conv_cb, conv_cr
  );

  modport slave (
    input  src_rd, src_addr, conv_data, dst_wr, dst_addr, dst_wdata,
    output src_rdata, conv_y, conv_cb, conv_cr
  );

endinterface

// File: rtl/valid_delay_line.sv
// Shift register that follows each issued read through RAM and converter latency.
// A synchronous clear drops every in-flight pixel at once.
module valid_delay_line #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] line_q;
  logic [DEPTH-1:0] line_d;

  // NOTE: every path assigns line_d, so no latch is inferred for the next-state value.
  always_comb begin
    line_d = {line_q[DEPTH-2:0], in_valid};
    if (clr) begin
      line_d = '0;
    end
  end

  // NOTE: state is updated with <= so all flops sample their inputs from the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign out_valid = line_q[DEPTH-1];

endmodule

// File: rtl/ycbcr_frame_ctrl.sv
// Frame sequencer: streams a frame of RGB pixels through the free-running converter
// at one pixel per cycle and writes the packed Y/Cb/Cr bytes to the destination RAM.
module ycbcr_frame_ctrl
  import ycbcr_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int CONV_LAT = CONV_LAT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W:0]     frame_len,
  ycbcr_frame_ctrl_if.master  bus,
  output logic                busy,
  output logic                done
);

  // One extra stage for the conv_data register between RAM and converter.
  localparam int VLD_DEPTH = RD_LAT + 1 + CONV_LAT;

  state_e            state_q,    state_d;
  logic [ADDR_W:0]   len_q,      len_d;
  logic              src_rd_q,   src_rd_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  pixel_t            conv_data_q;

  logic              dst_wr;
  logic [ADDR_W:0]   last_idx;
  logic              last_rd;
  logic              last_wr;

  // A full 2^ADDR_W frame makes last_idx all ones in the low bits, so the counters wrap cleanly.
  assign last_idx = len_q - (ADDR_W + 1)'(1);
  assign last_rd  = (src_addr_q == last_idx[ADDR_W-1:0]);
  assign last_wr  = dst_wr && (dst_addr_q == last_idx[ADDR_W-1:0]);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    src_addr_d = src_rd_q ? src_addr_q + ADDR_W'(1) : src_addr_q;
    dst_addr_d = dst_wr   ? dst_addr_q + ADDR_W'(1) : dst_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d      = frame_len;
          src_addr_d = '0;
          dst_addr_d = '0;
          state_d    = (frame_len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (last_rd) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_wr) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort beats start and drops the frame without a done pulse.
    if (abort) begin
      state_d = ST_IDLE;
    end

    src_rd_d = (state_d == ST_RUN);
    busy_d   = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      src_rd_q    <= 1'b0;
      src_addr_q  <= '0;
      dst_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      conv_data_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      src_rd_q    <= src_rd_d;
      src_addr_q  <= src_addr_d;
      dst_addr_q  <= dst_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      conv_data_q <= bus.src_rdata;
    end
  end

  valid_delay_line #(
    .DEPTH (VLD_DEPTH)
  ) u_vld (
    .clk       (clk),
    .reset     (reset),
    .clr       (abort),
    .in_valid  (src_rd_q),
    .out_valid (dst_wr)
  );

  assign bus.src_rd    = src_rd_q;
  assign bus.src_addr  = src_addr_q;
  assign bus.conv_data = conv_data_q;
  assign bus.dst_wr    = dst_wr;
  assign bus.dst_addr  = dst_addr_q;
  assign bus.dst_wdata = pack_ycc(bus.conv_y, bus.conv_cb, bus.conv_cr);
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_ycbcr_frame_ctrl.sv
// Bench for ycbcr_frame_ctrl: source RAM and 3-stage converter models around the DUT,
// with every cycle of each frame checked against the frame timing rules.
module tb_ycbcr_frame_ctrl;
  import ycbcr_pkg::*;

  localparam int ADDR_W = 10;
  localparam int NPIX   = 1 << ADDR_W;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [ADDR_W:0] frame_len = '0;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_fail   = 0;
  bit force_conv = 1'b0;

  pixel_t      mem [NPIX];
  logic [47:0] s1 = '0, s2 = '0, s3 = '0;

  ycbcr_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus_if ();

  ycbcr_frame_ctrl #(
    .ADDR_W   (ADDR_W),
    .CONV_LAT (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .frame_len (frame_len),
    .bus       (bus_if),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Integer BT.601-style conversion, 8.8 fixed point with a 128 offset on chroma.
  function automatic logic [47:0] conv_fn(input pixel_t p);
    int r, g, b, y, cb, cr;
    r  = int'(p[23:16]);
    g  = int'(p[15:8]);
    b  = int'(p[7:0]);
    y  = 77 * r + 150 * g + 29 * b;
    cb = 32768 - 43 * r - 85 * g + 128 * b;
    cr = 32768 + 128 * r - 107 * g - 21 * b;
    return {16'(y), 16'(cb), 16'(cr)};
  endfunction

  function automatic pixel_t ref_wdata(input pixel_t p);
    int r, g, b, y, cb, cr;
    r  = int'(p[23:16]);
    g  = int'(p[15:8]);
    b  = int'(p[7:0]);
    y  = 77 * r + 150 * g + 29 * b;
    cb = 32768 - 43 * r - 85 * g + 128 * b;
    cr = 32768 + 128 * r - 107 * g - 21 * b;
    return {8'(y / 256), 8'(cb / 256), 8'(cr / 256)};
  endfunction

  always @(posedge clk) begin
    if (bus_if.src_rd) bus_if.src_rdata <= mem[bus_if.src_addr];
  end
  initial bus_if.src_rdata = '0;

  always @(posedge clk) begin
    s1 <= conv_fn(bus_if.conv_data);
    s2 <= s1;
    s3 <= s2;
  end

  assign bus_if.conv_y  = force_conv ? 16'hAB12 : s3[47:32];
  assign bus_if.conv_cb = force_conv ? 16'h8034 : s3[31:16];
  assign bus_if.conv_cr = force_conv ? 16'h7F56 : s3[15:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < NPIX; i++) mem[i] = pixel_t'($urandom);
  endtask

  // Start a frame of n pixels at cycle 0, then check cycles 1..n+8 against the timing rules.
  // abort_c / rst_c / restart_c name the cycle in which that event is driven (0 = none).
  task automatic run_frame(input int n, input int abort_c, input int rst_c, input int restart_c);
    int  done_c;
    bit  killed, exp_rd, exp_wr, exp_busy, exp_done;
    int  k;
    done_c = (n == 0) ? 1 : n + 6;
    @(posedge clk); #1;
    start     = 1'b1;
    frame_len = (ADDR_W + 1)'(n);
    for (int c = 1; c <= n + 8; c++) begin
      @(posedge clk); #1;
      start = (c == restart_c);
      if (c == restart_c) frame_len = frame_len + 3;
      abort = (c == abort_c);
      reset = (c != rst_c);
      killed   = (abort_c > 0 && c > abort_c) || (rst_c > 0 && c > rst_c);
      exp_rd   = !killed && c <= n;
      exp_wr   = !killed && c >= 6 && c <= n + 5;
      exp_busy = !killed && n > 0 && c <= n + 5;
      exp_done = !killed && c == done_c;
      check("src_rd", bus_if.src_rd, exp_rd);
      if (exp_rd) check("src_addr", bus_if.src_addr, c - 1);
      check("dst_wr", bus_if.dst_wr, exp_wr);
      if (exp_wr) begin
        k = c - 6;
        check("dst_addr", bus_if.dst_addr, k);
        check("dst_wdata", bus_if.dst_wdata, force_conv ? 24'hAB807F : ref_wdata(mem[k]));
        if (!force_conv && mem[k] == 24'hFFFFFF)
          check("y_byte_white", bus_if.dst_wdata[23:16], 8'hFF);
      end
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      if (!killed && c >= 3 && c <= n + 2) check("conv_data", bus_if.conv_data, mem[c - 3]);
      if (rst_c > 0 && c == rst_c + 1) begin
        check("rst_src_addr", bus_if.src_addr, 0);
        check("rst_dst_addr", bus_if.dst_addr, 0);
        check("rst_conv_data", bus_if.conv_data, 0);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    fill_mem();
    repeat (2) @(posedge clk);
    #1;
    check("reset_src_rd", bus_if.src_rd, 0);
    check("reset_src_addr", bus_if.src_addr, 0);
    check("reset_dst_wr", bus_if.dst_wr, 0);
    check("reset_dst_addr", bus_if.dst_addr, 0);
    check("reset_conv_data", bus_if.conv_data, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic four-pixel frame.
    run_frame(4, 0, 0, 0);

    // Fixed converter outputs: upper bytes packed as {Y,Cb,Cr}.
    force_conv = 1'b1;
    run_frame(4, 0, 0, 0);
    force_conv = 1'b0;

    // A white pixel lands with Y byte FF at its own address.
    fill_mem();
    mem[2] = 24'hFFFFFF;
    run_frame(5, 0, 0, 0);

    // Empty frame: done right away, no traffic.
    run_frame(0, 0, 0, 0);

    // Abort mid-frame, then a short frame restarting from address 0.
    fill_mem();
    run_frame(8, 4, 0, 0);
    run_frame(2, 0, 0, 0);

    // A start pulse during RUN changes nothing.
    run_frame(6, 0, 0, 2);

    // Reset in cycle 3 of a frame, then a clean single-pixel frame.
    run_frame(8, 0, 3, 0);
    run_frame(1, 0, 0, 0);

    // Maximum frame: address counter runs to 2^ADDR_W-1.
    fill_mem();
    run_frame(NPIX, 0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      fill_mem();
      run_frame(int'($urandom_range(1, 40)), 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
